axi_mst_read_mo: RTL and testbench



---
 rtl/axi_mst_read_mo_pkg.sv | 19 +
 rtl/axi_mst_read_mo_if.sv | 53 +++++
 rtl/axi_mst_read_mo_fifo_sync.sv | 90 +++++++++
 rtl/axi_mst_read_mo.sv | 171 +++++++++++++++++
 tb/tb_axi_mst_read_mo.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mst_read_mo_pkg.sv
// Shared FSM state type, AXI encodings and helpers for the multi-outstanding read master.
package axi_mst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    // AXI arsize encoding: log2 of the number of bytes per beat.
    function automatic logic [2:0] SIZE_OF(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi_mst_read_mo_if.sv
// AXI4 read channels plus the AXIS output stream of the read master, bundled with master/slave views.
interface axi_mst_read_mo_if #(
    parameter int ID_WIDTH       = 6,
    parameter int DATA_WIDTH     = 64,
    parameter int B_BURST_LENGTH = 8
);

    logic [ID_WIDTH-1:0]       m_axi_arid;
    logic [31:0]               m_axi_araddr;
    logic [B_BURST_LENGTH-1:0] m_axi_arlen;
    logic [2:0]                m_axi_arsize;
    logic [1:0]                m_axi_arburst;
    logic                      m_axi_arlock;
    logic [3:0]                m_axi_arcache;
    logic [2:0]                m_axi_arprot;
    logic [3:0]                m_axi_arqos;
    logic                      m_axi_arvalid;
    logic                      m_axi_arready;

    logic [ID_WIDTH-1:0]       m_axi_rid;
    logic [DATA_WIDTH-1:0]     m_axi_rdata;
    logic [1:0]                m_axi_rresp;
    logic                      m_axi_rlast;
    logic                      m_axi_rvalid;
    logic                      m_axi_rready;

    logic                      m_axis_tvalid;
    logic [DATA_WIDTH-1:0]     m_axis_tdata;
    logic [DATA_WIDTH/8-1:0]   m_axis_tstrb;
    logic                      m_axis_tlast;
    logic                      m_axis_tready;

    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast,
        output m_axis_tready
    );

endinterface

// File: rtl/axi_mst_read_mo_fifo_sync.sv
// First-word-fall-through synchronous FIFO: a RAM body plus a registered output slot.
// Writes bypass the RAM straight into the output slot when it is free and the RAM is empty.
module fifo_sync #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             single
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    mem_count;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    logic pop;
    logic slot_free;
    logic mem_empty;
    logic bypass;
    logic mem_wr;
    logic mem_rd;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        pop       = out_valid && rd_en;
        slot_free = !out_valid || pop;
        mem_empty = (mem_count == '0);
        bypass    = wr_en && slot_free && mem_empty;
        mem_wr    = wr_en && !bypass;
        mem_rd    = slot_free && !mem_empty;
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (mem_rd) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (mem_wr && !mem_rd) begin
                mem_count <= mem_count + CW'(1);
            end else if (!mem_wr && mem_rd) begin
                mem_count <= mem_count - CW'(1);
            end
            // The output slot only changes when it is free, so data is held under backpressure.
            if (slot_free) begin
                out_valid <= bypass || mem_rd;
                if (bypass) begin
                    out_data <= wr_data;
                end else if (mem_rd) begin
                    out_data <= mem[rd_ptr];
                end
            end
        end
    end

    assign rd_data = out_data;
    assign empty   = !out_valid;
    assign full    = (mem_count == CW'(DEPTH));
    assign single  = out_valid && mem_empty;

endmodule

// File: rtl/axi_mst_read_mo.sv
// Multi-outstanding AXI4 read master streaming NBURST bursts to AXIS through a credit-managed FIFO.
// Define AXI_MST_READ_MO_ERR_EN to make ERR_REG a sticky non-OKAY RRESP flag; otherwise it is tied 0.
module axi_mst_read_mo
    import axi_mst_pkg::*;
#(
    parameter int ID_WIDTH        = 6,
    parameter int DATA_WIDTH      = 64,
    parameter int B_BURST_LENGTH  = 8,
    parameter int MAX_BEATS       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    axi_mst_read_mo_if.master        bus,
    input  logic                     START_REG,
    input  logic [31:0]              ADDR_REG,
    input  logic [31:0]              NBURST_REG,
    input  logic [7:0]               LEN_REG,
    output logic                     IDLE_REG,
    output logic                     ERR_REG
);

    localparam int FIFO_DEPTH = MAX_OUTSTANDING * MAX_BEATS;
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam int RES_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0] LEN_MAX = 8'(MAX_BEATS - 1);

    state_t            state;
    state_t            state_next;
    logic              start_prev;
    logic [31:0]       addr_q;
    logic [31:0]       bursts_left;
    logic [7:0]        len_q;
    logic [OUT_W-1:0]  outstanding;
    logic [RES_W-1:0]  reserved;

    logic              start_edge;
    logic [8:0]        beats;
    logic              credit_ok;
    logic              ar_hs;
    logic              r_hs;
    logic              rlast_hs;
    logic              pop;
    logic [DATA_WIDTH:0] fifo_rd_data;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_single;

    // An AR may only go out if both a slot in the outstanding window and buffer space for the whole burst exist.
    always_comb begin
        start_edge = START_REG && !start_prev;
        beats      = {1'b0, len_q} + 9'd1;
        credit_ok  = (32'(outstanding) < 32'(MAX_OUTSTANDING)) &&
                     ((32'(reserved) + 32'(beats)) <= 32'(FIFO_DEPTH));
        ar_hs      = bus.m_axi_arvalid && bus.m_axi_arready;
        r_hs       = bus.m_axi_rvalid && bus.m_axi_rready;
        rlast_hs   = r_hs && bus.m_axi_rlast;
        pop        = bus.m_axis_tvalid && bus.m_axis_tready;
    end

    always_comb begin
        state_next        = state;
        bus.m_axi_arvalid = (state == ISSUE) && credit_ok;
        bus.m_axi_rready  = (state != IDLE);
        IDLE_REG          = (state == IDLE);
        unique case (state)
            IDLE: begin
                if (start_edge) begin
                    state_next = (NBURST_REG == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (ar_hs && (bursts_left == 32'd1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Leave on the same edge that pops the final beat so IDLE_REG rises right after it.
                if ((outstanding == '0) && (fifo_empty || (fifo_single && pop))) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start_prev  <= 1'b0;
            addr_q      <= '0;
            bursts_left <= '0;
            len_q       <= '0;
            outstanding <= '0;
            reserved    <= '0;
        end else begin
            state      <= state_next;
            start_prev <= START_REG;
            if (state == IDLE) begin
                if (start_edge) begin
                    addr_q      <= ADDR_REG;
                    bursts_left <= NBURST_REG;
                    len_q       <= (LEN_REG > LEN_MAX) ? LEN_MAX : LEN_REG;
                    outstanding <= '0;
                    reserved    <= '0;
                end
            end else begin
                if (ar_hs) begin
                    addr_q      <= addr_q + (32'(beats) * 32'(BYTES));
                    bursts_left <= bursts_left - 32'd1;
                end
                outstanding <= outstanding + OUT_W'(ar_hs) - OUT_W'(rlast_hs);
                reserved    <= reserved + (ar_hs ? RES_W'(beats) : RES_W'(0)) - RES_W'(pop);
            end
        end
    end

    fifo_sync #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (r_hs),
        .wr_data ({bus.m_axi_rlast, bus.m_axi_rdata}),
        .rd_en   (bus.m_axis_tready),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .single  (fifo_single)
    );

    assign bus.m_axi_arid    = '0;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arlen   = B_BURST_LENGTH'(len_q);
    assign bus.m_axi_arsize  = SIZE_OF(DATA_WIDTH);
    assign bus.m_axi_arburst = BURST_INCR;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arcache = CACHE_DEFAULT;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_arqos   = 4'b0000;

    assign bus.m_axis_tvalid = !fifo_empty;
    assign bus.m_axis_tstrb  = '1;
    assign {bus.m_axis_tlast, bus.m_axis_tdata} = fifo_rd_data;

`ifdef AXI_MST_READ_MO_ERR_EN
    logic err_q;
    logic unused_sink;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state == IDLE) && start_edge) begin
            err_q <= 1'b0;
        end else if (r_hs && (bus.m_axi_rresp != RESP_OKAY)) begin
            err_q <= 1'b1;
        end
    end

    assign ERR_REG     = err_q;
    assign unused_sink = ^{bus.m_axi_rid, fifo_full};
`else
    logic unused_sink;

    assign ERR_REG     = 1'b0;
    assign unused_sink = ^{bus.m_axi_rid, bus.m_axi_rresp, fifo_full};
`endif

endmodule

// File: tb/tb_axi_mst_read_mo.sv
// Randomised bench for axi_mst_read_mo: a reactive AXI slave plus a burst/beat-list reference model.
`timescale 1ns/1ps
module tb_axi_mst_read_mo;

    localparam int DW    = 64;
    localparam int MAXO  = 4;
    localparam int MAXB  = 16;
    localparam int DEPTH = MAXO * MAXB;
    localparam int BYTES = DW / 8;
`ifdef AXI_MST_READ_MO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        START_REG = 1'b0;
    logic [31:0] ADDR_REG = '0;
    logic [31:0] NBURST_REG = '0;
    logic [7:0]  LEN_REG = '0;
    logic        IDLE_REG;
    logic        ERR_REG;

    axi_mst_read_mo_if #(.ID_WIDTH(6), .DATA_WIDTH(DW), .B_BURST_LENGTH(8)) bus ();

    axi_mst_read_mo #(
        .ID_WIDTH(6), .DATA_WIDTH(DW), .B_BURST_LENGTH(8),
        .MAX_BEATS(MAXB), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .START_REG(START_REG), .ADDR_REG(ADDR_REG), .NBURST_REG(NBURST_REG), .LEN_REG(LEN_REG),
        .IDLE_REG(IDLE_REG), .ERR_REG(ERR_REG)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatched = 0;

    // Reference model: the bursts and beats the specification says must appear, plus bookkeeping counts.
    logic [31:0] exp_ar_addr[$];
    logic [64:0] exp_beats[$];
    int          len_eff = 0;
    int          ars_left = 0;
    int          outstanding_m = 0;
    int          reserved_m = 0;
    int          ar_total = 0;
    bit          busy_exp = 1'b0;
    bit          zero_pending = 1'b0;
    bit          err_exp = 1'b0;

    // Pending start request and its parameters.
    bit          start_pending = 1'b0;
    logic [31:0] st_addr;
    int          st_nburst;
    int          st_len;
    logic [31:0] salt = 32'h0;

    // Slave-side state.
    logic [31:0] sl_addr[$];
    int          sl_len[$];
    int          sl_beat = 0;
    bit          r_busy = 1'b0;
    int          r_beat_num = 0;
    int          err_beat = 0;
    int          p_ar = 100;
    int          p_r = 100;
    int          p_t = 100;

    function automatic logic [63:0] beatData(input logic [31:0] a);
        return {a ^ salt, a};
    endfunction

    function automatic bit arvalidExpected();
        return busy_exp && (ars_left > 0) && (outstanding_m < MAXO) &&
               (reserved_m + len_eff + 1 <= DEPTH);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input int nburst, input int len);
        st_addr       = addr;
        st_nburst     = nburst;
        st_len        = len;
        ADDR_REG      = addr;
        NBURST_REG    = 32'(nburst);
        LEN_REG       = 8'(len);
        start_pending = 1'b1;
    endtask

    task automatic cycleStep();
        bit          ar_hs;
        bit          r_hs;
        bit          t_hs;
        logic [64:0] e;
        logic [31:0] a;
        @(negedge clk);
        checkOutput("idle", IDLE_REG, !busy_exp);
        checkOutput("err", ERR_REG, err_exp);
        checkOutput("rready", bus.m_axi_rready, busy_exp);
        checkOutput("arvalid", bus.m_axi_arvalid, arvalidExpected());
        if (bus.m_axis_tvalid) checkOutput("tvalid_spurious", exp_beats.size() > 0, 1);

        START_REG = start_pending;
        start_pending = 1'b0;
        bus.m_axi_arready = ($urandom_range(99) < p_ar);
        if (!r_busy && (sl_addr.size() > 0) && ($urandom_range(99) < p_r)) begin
            r_busy = 1'b1;
            r_beat_num++;
            bus.m_axi_rdata = beatData(sl_addr[0] + 32'(sl_beat * BYTES));
            bus.m_axi_rlast = (sl_beat == sl_len[0]);
            bus.m_axi_rresp = (r_beat_num == err_beat) ? 2'b10 : 2'b00;
            bus.m_axi_rid   = 6'($urandom);
        end else if (!r_busy) begin
            bus.m_axi_rdata = {$urandom, $urandom};
            bus.m_axi_rlast = 1'($urandom);
        end
        bus.m_axi_rvalid = r_busy;
        bus.m_axis_tready = ($urandom_range(99) < p_t);

        ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;
        r_hs  = bus.m_axi_rvalid && bus.m_axi_rready;
        t_hs  = bus.m_axis_tvalid && bus.m_axis_tready;

        if (zero_pending) begin
            busy_exp = 1'b0;
            zero_pending = 1'b0;
        end
        if (ar_hs) begin
            a = (exp_ar_addr.size() > 0) ? exp_ar_addr.pop_front() : 32'hDEAD_BEEF;
            checkOutput("araddr", bus.m_axi_araddr, a);
            checkOutput("arlen", bus.m_axi_arlen, len_eff);
            sl_addr.push_back(bus.m_axi_araddr);
            sl_len.push_back(int'(bus.m_axi_arlen));
            ars_left--;
            ar_total++;
            outstanding_m++;
            reserved_m += len_eff + 1;
            checkOutput("outstanding_bound", outstanding_m <= MAXO, 1);
            checkOutput("reserved_bound", reserved_m <= DEPTH, 1);
        end
        if (r_hs) begin
            r_busy = 1'b0;
            if (bus.m_axi_rresp != 2'b00) err_exp = ERR_EN;
            if (bus.m_axi_rlast) begin
                void'(sl_addr.pop_front());
                void'(sl_len.pop_front());
                sl_beat = 0;
                outstanding_m--;
            end else begin
                sl_beat++;
            end
        end
        if (t_hs) begin
            if (exp_beats.size() == 0) begin
                checkOutput("unexpected_beat", t_hs, 0);
            end else begin
                e = exp_beats.pop_front();
                checkOutput("tdata", bus.m_axis_tdata, e[63:0]);
                checkOutput("tlast", bus.m_axis_tlast, e[64]);
            end
            reserved_m--;
            if (busy_exp && (ars_left == 0) && (exp_beats.size() == 0)) busy_exp = 1'b0;
        end
        if (START_REG) begin
            len_eff = (st_len > MAXB - 1) ? MAXB - 1 : st_len;
            ars_left = st_nburst;
            busy_exp = 1'b1;
            err_exp = 1'b0;
            outstanding_m = 0;
            reserved_m = 0;
            ar_total = 0;
            r_beat_num = 0;
            exp_ar_addr.delete();
            exp_beats.delete();
            for (int b = 0; b < st_nburst; b++) begin
                exp_ar_addr.push_back(st_addr + 32'(b * (len_eff + 1) * BYTES));
                for (int k = 0; k <= len_eff; k++) begin
                    a = st_addr + 32'((b * (len_eff + 1) + k) * BYTES);
                    exp_beats.push_back({(k == len_eff), beatData(a)});
                end
            end
            if (st_nburst == 0) zero_pending = 1'b1;
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) cycleStep();
    endtask

    task automatic runUntilIdle(input int budget);
        int i = 0;
        do begin
            cycleStep();
            i++;
        end while ((busy_exp || start_pending) && (i < budget));
        if (busy_exp) checkOutput("run_timeout", busy_exp, 0);
        checkOutput("beats_remaining", exp_beats.size(), 0);
        cycleStep();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        START_REG = 1'b0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid = 1'b0;
        bus.m_axis_tready = 1'b0;
        r_busy = 1'b0;
        sl_addr.delete();
        sl_len.delete();
        sl_beat = 0;
        exp_ar_addr.delete();
        exp_beats.delete();
        busy_exp = 1'b0;
        zero_pending = 1'b0;
        start_pending = 1'b0;
        err_exp = 1'b0;
        ars_left = 0;
        outstanding_m = 0;
        reserved_m = 0;
        @(negedge clk);
        checkOutput("rst_arvalid", bus.m_axi_arvalid, 0);
        checkOutput("rst_araddr", bus.m_axi_araddr, 0);
        checkOutput("rst_arlen", bus.m_axi_arlen, 0);
        checkOutput("rst_rready", bus.m_axi_rready, 0);
        checkOutput("rst_tvalid", bus.m_axis_tvalid, 0);
        checkOutput("rst_tlast", bus.m_axis_tlast, 0);
        checkOutput("rst_tdata", bus.m_axis_tdata, 0);
        checkOutput("rst_idle", IDLE_REG, 1);
        checkOutput("rst_err", ERR_REG, 0);
        rst = 1'b0;
    endtask

    initial begin
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rresp   = 2'b00;
        bus.m_axi_rid     = '0;
        bus.m_axis_tready = 1'b0;

        doReset();
        checkOutput("arsize", bus.m_axi_arsize, 3);
        checkOutput("arburst", bus.m_axi_arburst, 1);
        checkOutput("arcache", bus.m_axi_arcache, 4'b0011);
        checkOutput("arlock_prot_qos", {bus.m_axi_arlock, bus.m_axi_arprot, bus.m_axi_arqos}, 0);
        checkOutput("arid", bus.m_axi_arid, 0);
        checkOutput("tstrb", bus.m_axis_tstrb, 8'hFF);

        $display("[TB] directed: 4 bursts of 8 beats, always ready");
        p_ar = 100; p_r = 100; p_t = 100; err_beat = 0; salt = 32'h1234_5678;
        applyStimulus(32'h1000, 4, 7);
        runUntilIdle(2000);
        checkOutput("ar_count_basic", ar_total, 4);

        $display("[TB] directed: R withheld, window limit");
        p_r = 0;
        applyStimulus(32'h0002_0000, 8, 15);
        runCycles(30);
        checkOutput("ars_while_r_stalled", ar_total, 4);
        p_r = 100;
        runUntilIdle(3000);

        $display("[TB] directed: AXIS stalled, credit limit");
        p_t = 0;
        applyStimulus(32'h0004_0000, 8, 15);
        runCycles(120);
        checkOutput("ars_while_t_stalled", ar_total, 4);
        p_t = 100;
        runUntilIdle(3000);

        $display("[TB] directed: zero bursts");
        applyStimulus(32'h5000, 0, 3);
        runUntilIdle(50);
        checkOutput("ar_count_zero", ar_total, 0);

        $display("[TB] directed: error response on beat 3");
        err_beat = 3;
        applyStimulus(32'h6000, 2, 3);
        runUntilIdle(500);
        runCycles(3);
        err_beat = 0;
        applyStimulus(32'h7000, 1, 0);
        runUntilIdle(500);

        $display("[TB] directed: reset mid-burst");
        applyStimulus(32'h8000, 6, 15);
        runCycles(20);
        doReset();
        applyStimulus(32'h9000, 3, 5);
        runUntilIdle(2000);

        $display("[TB] randomised runs");
        for (int n = 0; n < 10; n++) begin
            p_ar = $urandom_range(100, 30);
            p_r  = $urandom_range(100, 30);
            p_t  = $urandom_range(100, 30);
            err_beat = $urandom_range(20);
            salt = $urandom;
            applyStimulus($urandom & 32'hFFFF_FFF8, $urandom_range(10, 1),
                          (n % 3 == 0) ? $urandom_range(255) : $urandom_range(15));
            runUntilIdle(8000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
